// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the multi-item vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] C1   = 2'b00;
    localparam logic [1:0] C5   = 2'b01;
    localparam logic [1:0] C10  = 2'b10;
    localparam logic [1:0] CBAD = 2'b11;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        case (code)
            C1:      return 4'd1;
            C5:      return 4'd5;
            C10:     return 4'd10;
            default: return 4'd0;
        endcase
    endfunction

    // Greedy change: biggest denomination that does not overpay.
    function automatic logic [1:0] largest_coin(input int unsigned credit_val);
        if (credit_val >= 10)
            return C10;
        else if (credit_val >= 5)
            return C5;
        return C1;
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters: restock overrides a same-cycle decrement,
// and a decrement never takes an empty counter below zero.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = 3,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8,
    parameter int IDX_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid_i,
    input  logic [IDX_W-1:0]     dec_idx_i,
    input  logic                 restock_valid_i,
    input  logic [IDX_W-1:0]     restock_idx_i,
    output logic [NUM_ITEMS-1:0] sold_out_o
);

    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (restock_valid_i && (restock_idx_i == IDX_W'(i)))
                stock_d[i] = STOCK_W'(STOCK_INIT);
            else if (dec_valid_i && (dec_idx_i == IDX_W'(i)) && (stock_q[i] != '0))
                stock_d[i] = stock_q[i] - STOCK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ITEMS; i++)
                stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++)
                stock_q[i] <= stock_d[i];
        end
    end

    always_comb begin
        sold_out_o = '0;
        for (int i = 0; i < NUM_ITEMS; i++)
            sold_out_o[i] = (stock_q[i] == '0);
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: credit accumulation, selection, vend pulse
// and greedy coin-by-coin change over a valid/ready hopper interface.
// IDLE: no credit | CREDIT: accepting coins/selection | VEND: one-cycle dispense | CHANGE: paying out
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                            NUM_ITEMS  = 3,
    parameter int                            CREDIT_W   = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {8'd14, 8'd13, 8'd12},
    parameter int                            MAX_CREDIT = 200,
    parameter int                            STOCK_W    = 4,
    parameter int                            STOCK_INIT = 8,
    localparam int                           IDX_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin_valid,
    input  logic [1:0]           coin_code,
    input  logic                 sel_valid,
    input  logic [IDX_W-1:0]     sel_idx,
    input  logic                 cancel,
    input  logic                 restock_valid,
    input  logic [IDX_W-1:0]     restock_idx,
    output logic [NUM_ITEMS-1:0] vend,
    output logic                 deny,
    output logic                 coin_rej,
    output logic                 chng_valid,
    output logic [1:0]           chng_code,
    input  logic                 chng_ready,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic                 busy
);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [NUM_ITEMS-1:0]  vend_q, vend_d;
    logic                  deny_q, deny_d;
    logic                  coin_rej_q, coin_rej_d;
    logic                  chng_valid_q, chng_valid_d;
    logic [1:0]            chng_code_q, chng_code_d;

    logic [CREDIT_W:0]     coin_sum;
    logic                  coin_ok;
    logic                  sel_hit;
    logic                  sel_avail;
    logic [CREDIT_W-1:0]   sel_price;
    logic [NUM_ITEMS-1:0]  sel_onehot;
    logic                  sel_ok;
    logic                  dec_valid;
    logic [CREDIT_W-1:0]   chng_rem;

    vend_stock_bank #(
        .NUM_ITEMS  (NUM_ITEMS),
        .STOCK_W    (STOCK_W),
        .STOCK_INIT (STOCK_INIT),
        .IDX_W      (IDX_W)
    ) u_stock (
        .clk             (clk),
        .rst             (rst),
        .dec_valid_i     (dec_valid),
        .dec_idx_i       (sel_idx),
        .restock_valid_i (restock_valid),
        .restock_idx_i   (restock_idx),
        .sold_out_o      (sold_out)
    );

    // Out-of-range indices simply never hit, which makes them deniable.
    always_comb begin
        sel_hit    = 1'b0;
        sel_avail  = 1'b0;
        sel_price  = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_hit       = 1'b1;
                sel_avail     = !sold_out[i];
                sel_price     = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign sel_ok   = sel_hit && sel_avail && (credit_q >= sel_price);
    assign coin_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_code));
    assign coin_ok  = (coin_code != CBAD) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign chng_rem = credit_q - CREDIT_W'(coin_value(chng_code_q));

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        vend_d       = '0;
        deny_d       = 1'b0;
        coin_rej_d   = 1'b0;
        chng_valid_d = chng_valid_q;
        chng_code_d  = chng_code_q;
        dec_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cancel || sel_valid) begin
                    deny_d     = sel_valid;
                    coin_rej_d = coin_valid;
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = CREDIT;
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end
            end

            CREDIT: begin
                if (cancel) begin
                    deny_d     = sel_valid;
                    coin_rej_d = coin_valid;
                    if (credit_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = CHANGE;
                        chng_valid_d = 1'b1;
                        chng_code_d  = largest_coin(32'(credit_q));
                    end
                end else if (sel_valid) begin
                    coin_rej_d = coin_valid;
                    if (sel_ok) begin
                        state_d   = VEND;
                        credit_d  = credit_q - sel_price;
                        vend_d    = sel_onehot;
                        dec_valid = 1'b1;
                    end else begin
                        deny_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_ok)
                        credit_d = coin_sum[CREDIT_W-1:0];
                    else
                        coin_rej_d = 1'b1;
                end
            end

            VEND: begin
                deny_d     = sel_valid;
                coin_rej_d = coin_valid;
                if (credit_q != '0) begin
                    state_d      = CHANGE;
                    chng_valid_d = 1'b1;
                    chng_code_d  = largest_coin(32'(credit_q));
                end else begin
                    state_d = IDLE;
                end
            end

            CHANGE: begin
                deny_d     = sel_valid;
                coin_rej_d = coin_valid;
                if (chng_valid_q && chng_ready) begin
                    credit_d = chng_rem;
                    if (chng_rem == '0) begin
                        state_d      = IDLE;
                        chng_valid_d = 1'b0;
                    end else begin
                        chng_code_d = largest_coin(32'(chng_rem));
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            vend_q       <= '0;
            deny_q       <= 1'b0;
            coin_rej_q   <= 1'b0;
            chng_valid_q <= 1'b0;
            chng_code_q  <= C1;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            vend_q       <= vend_d;
            deny_q       <= deny_d;
            coin_rej_q   <= coin_rej_d;
            chng_valid_q <= chng_valid_d;
            chng_code_q  <= chng_code_d;
        end
    end

    assign vend       = vend_q;
    assign deny       = deny_q;
    assign coin_rej   = coin_rej_q;
    assign chng_valid = chng_valid_q;
    assign chng_code  = chng_code_q;
    assign credit     = credit_q;
    assign busy       = (state_q == VEND) || (state_q == CHANGE);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi: each row's expected outputs are queued
// when it is driven and compared against what the DUT shows after the edge.
module tb_vend_ctrl_multi;

    localparam logic [1:0] K1 = 2'b00, K5 = 2'b01, K10 = 2'b10, KBAD = 2'b11;

    typedef struct packed {
        logic       cv;
        logic [1:0] cc;
        logic       sv;
        logic [1:0] si;
        logic       cn;
        logic       rdy;
        logic       rv;
        logic [1:0] ri;
    } in_t;

    typedef struct packed {
        logic [7:0] credit;
        logic [2:0] vend;
        logic       deny;
        logic       rej;
        logic       chv;
        logic [1:0] chc;
        logic       busy;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_code = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_idx = 2'b00;
    logic       cancel = 1'b0;
    logic       restock_valid = 1'b0;
    logic [1:0] restock_idx = 2'b00;
    logic       chng_ready = 1'b0;
    logic [2:0] vend;
    logic       deny;
    logic       coin_rej;
    logic       chng_valid;
    logic [1:0] chng_code;
    logic [7:0] credit;
    logic [2:0] sold_out;
    logic       busy;

    int   n_run = 0;
    int   n_fail = 0;
    int   m_stock [3];
    out_t sbq [$];
    out_t obq [$];

    always #5 clk = ~clk;

    vend_ctrl_multi u_dut (
        .clk           (clk),
        .rst           (rst),
        .coin_valid    (coin_valid),
        .coin_code     (coin_code),
        .sel_valid     (sel_valid),
        .sel_idx       (sel_idx),
        .cancel        (cancel),
        .restock_valid (restock_valid),
        .restock_idx   (restock_idx),
        .vend          (vend),
        .deny          (deny),
        .coin_rej      (coin_rej),
        .chng_valid    (chng_valid),
        .chng_code     (chng_code),
        .chng_ready    (chng_ready),
        .credit        (credit),
        .sold_out      (sold_out),
        .busy          (busy)
    );

    function automatic in_t mk_in(logic cv, logic [1:0] cc, logic sv, logic [1:0] si,
                                  logic cn, logic rdy, logic rv, logic [1:0] ri);
        in_t s;
        s.cv = cv; s.cc = cc; s.sv = sv; s.si = si;
        s.cn = cn; s.rdy = rdy; s.rv = rv; s.ri = ri;
        return s;
    endfunction

    function automatic out_t mk_out(logic [7:0] cr, logic [2:0] vd, logic dn, logic rj,
                                    logic chv, logic [1:0] chc, logic bz);
        out_t o;
        o.credit = cr; o.vend = vd; o.deny = dn; o.rej = rj;
        o.chv = chv; o.chc = chc; o.busy = bz;
        return o;
    endfunction

    function automatic in_t f_nop();              return mk_in(0, K1, 0, 0, 0, 0, 0, 0); endfunction
    function automatic in_t f_coin(logic [1:0] c); return mk_in(1, c, 0, 0, 0, 0, 0, 0);  endfunction
    function automatic in_t f_sel(logic [1:0] i);  return mk_in(0, K1, 1, i, 0, 0, 0, 0); endfunction
    function automatic in_t f_cancel();           return mk_in(0, K1, 0, 0, 1, 0, 0, 0); endfunction
    function automatic in_t f_rdy();              return mk_in(0, K1, 0, 0, 0, 1, 0, 0); endfunction

    // Drive one cycle of stimulus, queue its expectation, record the DUT response.
    task automatic drive_row(input in_t s, input out_t e);
        out_t o;
        coin_valid = s.cv; coin_code = s.cc; sel_valid = s.sv; sel_idx = s.si;
        cancel = s.cn; chng_ready = s.rdy; restock_valid = s.rv; restock_idx = s.ri;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        o.credit = credit; o.vend = vend; o.deny = deny; o.rej = coin_rej;
        o.chv = chng_valid; o.busy = busy;
        o.chc = e.chv ? chng_code : e.chc;
        obq.push_back(o);
        coin_valid = 0; sel_valid = 0; cancel = 0; chng_ready = 0; restock_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) m_stock[i] = 8;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #2;
        n_run++;
        if ({credit, vend, deny, coin_rej, chng_valid, chng_code, busy} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got credit=%0d vend=%b deny=%b rej=%b chv=%b chc=%b busy=%b, want all zero",
                     credit, vend, deny, coin_rej, chng_valid, chng_code, busy);
        end
        n_run++;
        if (sold_out !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_sold_out: got %b want 000", sold_out);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) m_stock[i] = 8;
    endtask

    task automatic test_vend_exact();
        out_t o, e;
        int   k = 0;
        drive_row(f_coin(K10), mk_out(10, 0, 0, 0, 0, 0, 0));
        drive_row(f_coin(K1),  mk_out(11, 0, 0, 0, 0, 0, 0));
        drive_row(f_coin(K1),  mk_out(12, 0, 0, 0, 0, 0, 0));
        drive_row(f_sel(0),    mk_out(0, 3'b001, 0, 0, 0, 0, 1));
        m_stock[0]--;
        drive_row(f_nop(),     mk_out(0, 0, 0, 0, 0, 0, 0));
        drive_row(f_nop(),     mk_out(0, 0, 0, 0, 0, 0, 0));
        while (obq.size() != 0) begin
            o = obq.pop_front(); e = sbq.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL vend_exact[%0d]: got credit=%0d vend/deny/rej/chv/chc/busy=%b want credit=%0d %b",
                         k, o.credit, o[8:0], e.credit, e[8:0]);
            end
            k++;
        end
        n_run++;
        if (u_dut.u_stock.stock_q[0] !== 4'(m_stock[0])) begin
            n_fail++;
            $display("FAIL vend_exact_stock0: got %0d want %0d", u_dut.u_stock.stock_q[0], m_stock[0]);
        end
    endtask

    task automatic test_change_handshake();
        out_t o, e;
        int   k = 0;
        drive_row(f_coin(K10), mk_out(10, 0, 0, 0, 0, 0, 0));
        drive_row(f_coin(K10), mk_out(20, 0, 0, 0, 0, 0, 0));
        drive_row(f_sel(2),    mk_out(6, 3'b100, 0, 0, 0, 0, 1));
        m_stock[2]--;
        drive_row(f_nop(),     mk_out(6, 0, 0, 0, 1, K5, 1));
        for (int i = 0; i < 3; i++)
            drive_row(f_nop(), mk_out(6, 0, 0, 0, 1, K5, 1));
        drive_row(f_rdy(),     mk_out(1, 0, 0, 0, 1, K1, 1));
        drive_row(f_rdy(),     mk_out(0, 0, 0, 0, 0, 0, 0));
        drive_row(f_rdy(),     mk_out(0, 0, 0, 0, 0, 0, 0));
        while (obq.size() != 0) begin
            o = obq.pop_front(); e = sbq.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL change_handshake[%0d]: got credit=%0d vend/deny/rej/chv/chc/busy=%b want credit=%0d %b",
                         k, o.credit, o[8:0], e.credit, e[8:0]);
            end
            k++;
        end
        n_run++;
        if (u_dut.u_stock.stock_q[2] !== 4'(m_stock[2])) begin
            n_fail++;
            $display("FAIL change_stock2: got %0d want %0d", u_dut.u_stock.stock_q[2], m_stock[2]);
        end
    endtask

    task automatic test_deny_cancel();
        out_t o, e;
        int   k = 0;
        drive_row(f_coin(K10), mk_out(10, 0, 0, 0, 0, 0, 0));
        drive_row(f_coin(K1),  mk_out(11, 0, 0, 0, 0, 0, 0));
        drive_row(f_sel(1),    mk_out(11, 0, 1, 0, 0, 0, 0));
        drive_row(f_cancel(),  mk_out(11, 0, 0, 0, 1, K10, 1));
        drive_row(mk_in(1, K1, 0, 0, 0, 1, 0, 0), mk_out(1, 0, 0, 1, 1, K1, 1));
        drive_row(f_rdy(),     mk_out(0, 0, 0, 0, 0, 0, 0));
        while (obq.size() != 0) begin
            o = obq.pop_front(); e = sbq.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL deny_cancel[%0d]: got credit=%0d vend/deny/rej/chv/chc/busy=%b want credit=%0d %b",
                         k, o.credit, o[8:0], e.credit, e[8:0]);
            end
            k++;
        end
    endtask

    task automatic test_saturation();
        out_t o, e;
        int   k = 0;
        for (int i = 1; i <= 19; i++)
            drive_row(f_coin(K10), mk_out(8'(10 * i), 0, 0, 0, 0, 0, 0));
        drive_row(f_coin(K5),   mk_out(195, 0, 0, 0, 0, 0, 0));
        drive_row(f_coin(K10),  mk_out(195, 0, 0, 1, 0, 0, 0));
        drive_row(f_coin(K5),   mk_out(200, 0, 0, 0, 0, 0, 0));
        drive_row(f_coin(KBAD), mk_out(200, 0, 0, 1, 0, 0, 0));
        drive_row(f_coin(K1),   mk_out(200, 0, 0, 1, 0, 0, 0));
        drive_row(f_cancel(),   mk_out(200, 0, 0, 0, 1, K10, 1));
        for (int i = 1; i <= 20; i++)
            drive_row(f_rdy(), mk_out(8'(200 - 10 * i), 0, 0, 0, i < 20, K10, i < 20));
        while (obq.size() != 0) begin
            o = obq.pop_front(); e = sbq.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got credit=%0d vend/deny/rej/chv/chc/busy=%b want credit=%0d %b",
                         k, o.credit, o[8:0], e.credit, e[8:0]);
            end
            k++;
        end
    endtask

    task automatic test_sold_out_restock();
        out_t o, e;
        int   k = 0;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            drive_row(f_coin(K10), mk_out(10, 0, 0, 0, 0, 0, 0));
            drive_row(f_coin(K1),  mk_out(11, 0, 0, 0, 0, 0, 0));
            drive_row(f_coin(K1),  mk_out(12, 0, 0, 0, 0, 0, 0));
            drive_row(f_sel(0),    mk_out(0, 3'b001, 0, 0, 0, 0, 1));
            m_stock[0]--;
            drive_row(f_nop(),     mk_out(0, 0, 0, 0, 0, 0, 0));
        end
        n_run++;
        if (sold_out !== 3'b001 || u_dut.u_stock.stock_q[0] !== 4'(m_stock[0])) begin
            n_fail++;
            $display("FAIL sold_out_after_8: got sold_out=%b stock0=%0d want 001 %0d",
                     sold_out, u_dut.u_stock.stock_q[0], m_stock[0]);
        end
        drive_row(f_coin(K10), mk_out(10, 0, 0, 0, 0, 0, 0));
        drive_row(f_coin(K10), mk_out(20, 0, 0, 0, 0, 0, 0));
        drive_row(f_sel(0),    mk_out(20, 0, 1, 0, 0, 0, 0));
        drive_row(f_sel(3),    mk_out(20, 0, 1, 0, 0, 0, 0));
        drive_row(mk_in(0, K1, 0, 0, 0, 0, 1, 3), mk_out(20, 0, 0, 0, 0, 0, 0));
        n_run++;
        if (sold_out !== 3'b001 || u_dut.u_stock.stock_q[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL restock_out_of_range: got sold_out=%b stock0=%0d want 001 0",
                     sold_out, u_dut.u_stock.stock_q[0]);
        end
        drive_row(mk_in(0, K1, 0, 0, 0, 0, 1, 0), mk_out(20, 0, 0, 0, 0, 0, 0));
        m_stock[0] = 8;
        n_run++;
        if (sold_out !== 3'b000 || u_dut.u_stock.stock_q[0] !== 4'(m_stock[0])) begin
            n_fail++;
            $display("FAIL restock_item0: got sold_out=%b stock0=%0d want 000 %0d",
                     sold_out, u_dut.u_stock.stock_q[0], m_stock[0]);
        end
        // Vend and restock of item 0 together: restock value survives.
        drive_row(mk_in(0, K1, 1, 0, 0, 0, 1, 0), mk_out(8, 3'b001, 0, 0, 0, 0, 1));
        drive_row(f_nop(), mk_out(8, 0, 0, 0, 1, K5, 1));
        drive_row(f_rdy(), mk_out(3, 0, 0, 0, 1, K1, 1));
        drive_row(f_rdy(), mk_out(2, 0, 0, 0, 1, K1, 1));
        drive_row(f_rdy(), mk_out(1, 0, 0, 0, 1, K1, 1));
        drive_row(f_rdy(), mk_out(0, 0, 0, 0, 0, 0, 0));
        n_run++;
        if (u_dut.u_stock.stock_q[0] !== 4'(m_stock[0])) begin
            n_fail++;
            $display("FAIL restock_vs_vend: got stock0=%0d want %0d", u_dut.u_stock.stock_q[0], m_stock[0]);
        end
        while (obq.size() != 0) begin
            o = obq.pop_front(); e = sbq.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sold_out_restock[%0d]: got credit=%0d vend/deny/rej/chv/chc/busy=%b want credit=%0d %b",
                         k, o.credit, o[8:0], e.credit, e[8:0]);
            end
            k++;
        end
    endtask

    task automatic test_reset_midop_priority();
        out_t o, e;
        int   k = 0;
        drive_row(f_coin(K10), mk_out(10, 0, 0, 0, 0, 0, 0));
        drive_row(f_coin(K5),  mk_out(15, 0, 0, 0, 0, 0, 0));
        drive_row(f_coin(K1),  mk_out(16, 0, 0, 0, 0, 0, 0));
        drive_row(f_cancel(),  mk_out(16, 0, 0, 0, 1, K10, 1));
        drive_row(f_nop(),     mk_out(16, 0, 0, 0, 1, K10, 1));
        drive_row(f_rdy(),     mk_out(6, 0, 0, 0, 1, K5, 1));
        #2;
        rst = 1'b0;
        #1;
        n_run++;
        if ({credit, vend, deny, coin_rej, chng_valid, chng_code, busy, sold_out} !== 20'd0) begin
            n_fail++;
            $display("FAIL midop_async_reset: got credit=%0d vend=%b chv=%b chc=%b busy=%b sold_out=%b want all zero",
                     credit, vend, chng_valid, chng_code, busy, sold_out);
        end
        for (int i = 0; i < 3; i++) begin
            n_run++;
            if (u_dut.u_stock.stock_q[i] !== 4'd8) begin
                n_fail++;
                $display("FAIL midop_stock[%0d]: got %0d want 8", i, u_dut.u_stock.stock_q[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) m_stock[i] = 8;
        drive_row(f_coin(K10), mk_out(10, 0, 0, 0, 0, 0, 0));
        drive_row(mk_in(1, K1, 1, 0, 1, 0, 0, 0), mk_out(10, 0, 1, 1, 1, K10, 1));
        drive_row(f_rdy(), mk_out(0, 0, 0, 0, 0, 0, 0));
        while (obq.size() != 0) begin
            o = obq.pop_front(); e = sbq.pop_front(); n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL midop_priority[%0d]: got credit=%0d vend/deny/rej/chv/chc/busy=%b want credit=%0d %b",
                         k, o.credit, o[8:0], e.credit, e[8:0]);
            end
            k++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vend_exact();
        test_change_handshake();
        test_deny_cancel();
        test_saturation();
        test_sold_out_restock();
        test_reset_midop_priority();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
